// File: rtl/qrisc32_imem_slave.sv
// Instruction-memory slave for the qrisc32 fetch link: word array, per-address wait states,
// preload write port, sticky fetch-error flag. Optional random stalls: QRISC32_IMEM_RANDSTALL_EN.
module qrisc32_imem_slave #(
    parameter int          AW          = 10,
    parameter int          WAIT_STATES = 0,
    parameter string       INIT_FILE   = "",
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic          clk,
    input  logic          areset,
    input  logic [31:0]   address_r,
    input  logic          rd,
    output logic [31:0]   data_r,
    output logic          wait_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    output logic          err
);

    localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam bit         HAS_WAIT = (WAIT_STATES != 0);

    logic [31:0] mem [2**AW];

    logic [31:0] addr_q;
    logic        vld_q;
    logic [3:0]  cnt_q;
    logic        err_q;

    logic        new_req;
    logic        base_wait;
    logic        rand_stall;
    logic        out_of_range;
    logic        misaligned;

    assign new_req      = rd & (~vld_q | (address_r != addr_q));
    assign base_wait    = rd & ((cnt_q != 4'd0) | (new_req & HAS_WAIT));
    assign out_of_range = (address_r >> (AW + 2)) != 32'd0;
    assign misaligned   = address_r[1:0] != 2'b00;

`ifdef QRISC32_IMEM_RANDSTALL_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    // Fibonacci taps 16,14,13,11
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge clk or posedge areset) begin
        if (areset) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end

    assign rand_stall = rd & (cnt_q == 4'd0) & ~new_req & (lfsr_q[1:0] == 2'b00);
`else
    assign rand_stall = 1'b0;
`endif

    // Handshake: data_r is valid exactly in cycles with rd=1 and wait_req=0; while wait_req=1
    // the master holds address_r. wait_req is combinational so data is usable the same cycle.
    assign wait_req = ~areset & (base_wait | rand_stall);
    assign data_r   = (~areset & rd & ~wait_req & ~out_of_range) ? mem[address_r[AW+1:2]] : 32'd0;
    assign err      = err_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            addr_q <= 32'd0;
            vld_q  <= 1'b0;
            cnt_q  <= 4'd0;
            err_q  <= 1'b0;
        end else begin
            if (!rd) begin
                vld_q <= 1'b0;
            end else if (new_req) begin
                addr_q <= address_r;
                vld_q  <= 1'b1;
                cnt_q  <= CNT_LOAD;
            end else if (cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (rd && (out_of_range || misaligned)) err_q <= 1'b1;
        end
    end

    // Array is deliberately not reset; contents survive areset.
    always_ff @(posedge clk) begin
        if (ld_we) mem[ld_addr] <= ld_data;
    end

endmodule
